// File: rtl/ca_mem_pkg.sv
// Shared definitions for the MEM-stage memory controllers.
package ca_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_e;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  localparam int unsigned WAIT_CYCLES_MIN = 1;
  localparam int unsigned WAIT_CYCLES_MAX = 15;
  localparam int unsigned WAIT_CNT_W      = $clog2(WAIT_CYCLES_MAX + 1);

endpackage

// File: rtl/mem_addr_map.sv
// Byte address to SRAM word translation with range and alignment checking.
module mem_addr_map
  import ca_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic [ADDR_W-1:0]     alu_result,
  output logic [MEM_ADDR_W-1:0] word_addr,
  output logic                  addr_err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] word_full;

  always_comb begin
    off       = alu_result - BASE;
    word_full = off >> 2;
    word_addr = word_full[MEM_ADDR_W-1:0];
    // Any word-index bit above the SRAM depth means the access is out of range.
    addr_err  = (alu_result < BASE)
              || (alu_result[1:0] != 2'b00)
              || ((word_full >> MEM_ADDR_W) != '0);
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller for a wait-stated external SRAM; drops ready while busy.
module sram_mem_ctrl
  import ca_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_ADDR_W  = 16,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [ADDR_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     st_val,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  ready,
  output logic                  addr_err,
  output logic [MEM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  sram_we_n
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  mem_state_e            state, state_d;
  logic [WAIT_CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic                  is_write, is_write_d;
  logic [DATA_W-1:0]     rd_data_d, sram_dq_o_d;
  logic [MEM_ADDR_W-1:0] sram_addr_d, word_addr;
  logic                  addr_err_d, sram_dq_oe_d, sram_we_n_d;
  logic                  map_err, req, last;

  mem_addr_map #(
    .ADDR_W    (ADDR_W),
    .MEM_ADDR_W(MEM_ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_map (
    .alu_result(alu_result),
    .word_addr (word_addr),
    .addr_err  (map_err)
  );

  assign req     = mem_r_en | mem_w_en;
  assign last    = (cnt == LAST_CNT);
  assign cnt_inc = cnt + WAIT_CNT_W'(1);
  assign ready   = rst | ~req | (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_write   <= 1'b0;
      rd_data    <= '0;
      addr_err   <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      is_write   <= is_write_d;
      rd_data    <= rd_data_d;
      addr_err   <= addr_err_d;
      sram_addr  <= sram_addr_d;
      sram_dq_o  <= sram_dq_o_d;
      sram_dq_oe <= sram_dq_oe_d;
      sram_we_n  <= sram_we_n_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (req) state_d = map_err ? DONE : ACCESS;
      ACCESS:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes the next value of every registered output.
  always_comb begin
    cnt_d        = cnt;
    is_write_d   = is_write;
    rd_data_d    = rd_data;
    addr_err_d   = addr_err;
    sram_addr_d  = sram_addr;
    sram_dq_o_d  = sram_dq_o;
    sram_dq_oe_d = sram_dq_oe;
    sram_we_n_d  = sram_we_n;
    unique case (state)
      IDLE: begin
        if (req && map_err) begin
          addr_err_d = 1'b1;
          rd_data_d  = '0;
        end else if (req) begin
          // Write wins when both enables are set.
          is_write_d   = mem_w_en;
          cnt_d        = '0;
          sram_addr_d  = word_addr;
          sram_dq_o_d  = st_val;
          sram_dq_oe_d = mem_w_en;
          sram_we_n_d  = ~mem_w_en | (LAST_CNT == '0);
        end
      end
      ACCESS: begin
        if (last) begin
          sram_dq_oe_d = 1'b0;
          sram_we_n_d  = 1'b1;
          if (!is_write) rd_data_d = sram_dq_i;
        end else begin
          cnt_d = cnt_inc;
          // Strobe released one cycle early so address/data are held.
          sram_we_n_d = ~is_write | (cnt_inc == LAST_CNT);
        end
      end
      DONE:    addr_err_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed self-checking bench for sram_mem_ctrl (WAIT_CYCLES=4 and =1 instances).
module tb_sram_mem_ctrl;
  import ca_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst1 = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] alu_result = '0, st_val = '0;
  logic [31:0] rd_data, sram_dq_o, sram_dq_i;
  logic        ready, addr_err, sram_dq_oe, sram_we_n;
  logic [15:0] sram_addr;

  logic        mem_r_en1 = 1'b0, mem_w_en1 = 1'b0;
  logic [31:0] alu_result1 = '0, st_val1 = '0;
  logic [31:0] rd_data1, sram_dq_o1;
  logic [31:0] sram_dq_i1 = 32'hCAFE_F00D;
  logic        ready1, addr_err1, sram_dq_oe1, sram_we_n1;
  logic [15:0] sram_addr1;

  logic        mem_init = 1'b1;
  logic [31:0] sram_mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(4), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .st_val(st_val), .rd_data(rd_data), .ready(ready),
    .addr_err(addr_err), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst1), .mem_r_en(mem_r_en1), .mem_w_en(mem_w_en1),
    .alu_result(alu_result1), .st_val(st_val1), .rd_data(rd_data1), .ready(ready1),
    .addr_err(addr_err1), .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1),
    .sram_dq_oe(sram_dq_oe1), .sram_dq_i(sram_dq_i1), .sram_we_n(sram_we_n1)
  );

  // Simple SRAM model: write on an edge where the strobe and bus drive are active.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 256; i++) sram_mem[i] <= '0;
    end else if (!sram_we_n && sram_dq_oe) begin
      sram_mem[sram_addr[7:0]] <= sram_dq_o;
    end
  end
  assign sram_dq_i = sram_mem[sram_addr[7:0]];

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++;
    if ({rd_data, addr_err, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n} !== {32'h0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_regs got rd=%h err=%b addr=%h dq=%h oe=%b we_n=%b", rd_data, addr_err, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n);
    end
    n_cmp++;
    if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
    @(posedge clk); #1;
    rst = 1'b0; rst1 = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %b want 1", ready); end
  endtask

  // Write (optionally with mem_r_en also set); checks strobe timing and rd_data hold.
  task automatic test_write(input logic both, input logic [31:0] addr, input logic [31:0] data,
                            input logic [15:0] word, input logic [31:0] exp_rd);
    logic exp_rdy, exp_we_n, exp_oe;
    @(posedge clk); #1;
    mem_w_en = 1'b1; mem_r_en = both; alu_result = addr; st_val = data;
    for (int unsigned c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp_rdy  = (c == 5);
      exp_we_n = !(c >= 1 && c <= 3);
      exp_oe   = (c >= 1 && c <= 4);
      n_cmp++;
      if ({ready, sram_we_n, sram_dq_oe} !== {exp_rdy, exp_we_n, exp_oe}) begin
        n_bad++;
        $display("FAIL write_seq c%0d got rdy/we_n/oe=%b%b%b want %b%b%b", c, ready, sram_we_n, sram_dq_oe, exp_rdy, exp_we_n, exp_oe);
      end
      if (c == 1) begin
        n_cmp++;
        if (sram_addr !== word || sram_dq_o !== data) begin
          n_bad++; $display("FAIL write_addr got %h/%h want %h/%h", sram_addr, sram_dq_o, word, data);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (rd_data !== exp_rd) begin n_bad++; $display("FAIL write_rd_hold got %h want %h", rd_data, exp_rd); end
        n_cmp++;
        if (sram_mem[word[7:0]] !== data) begin
          n_bad++; $display("FAIL write_stored got %h want %h", sram_mem[word[7:0]], data);
        end
      end
      if (c < 5) @(posedge clk);
    end
    @(posedge clk); #1;
    mem_w_en = 1'b0; mem_r_en = 1'b0;
  endtask

  task automatic test_read(input logic [31:0] addr, input logic [15:0] word, input logic [31:0] exp_rd,
                           input logic [31:0] prev_rd);
    @(posedge clk); #1;
    mem_r_en = 1'b1; alu_result = addr;
    for (int unsigned c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ready, sram_we_n, sram_dq_oe} !== {(c == 5), 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL read_seq c%0d got rdy/we_n/oe=%b%b%b want %b10", c, ready, sram_we_n, sram_dq_oe, (c == 5));
      end
      if (c == 1) begin
        n_cmp++;
        if (sram_addr !== word) begin n_bad++; $display("FAIL read_addr got %h want %h", sram_addr, word); end
      end
      if (c == 4 || c == 5) begin
        n_cmp++;
        if (rd_data !== ((c == 5) ? exp_rd : prev_rd)) begin
          n_bad++; $display("FAIL read_data c%0d got %h want %h", c, rd_data, (c == 5) ? exp_rd : prev_rd);
        end
      end
      if (c < 5) @(posedge clk);
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0;
  endtask

  task automatic test_addr_err(input logic [31:0] addr);
    @(posedge clk); #1;
    mem_r_en = 1'b1; alu_result = addr;
    for (int unsigned c = 0; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ready, addr_err} !== {(c != 0), (c == 1)}) begin
        n_bad++;
        $display("FAIL err_seq %0d c%0d got rdy/err=%b%b want %b%b", addr, c, ready, addr_err, (c != 0), (c == 1));
      end
      n_cmp++;
      if ({sram_we_n, sram_dq_oe} !== 2'b10) begin
        n_bad++; $display("FAIL err_strobe %0d c%0d got we_n/oe=%b%b want 10", addr, c, sram_we_n, sram_dq_oe);
      end
      if (c == 1) begin
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL err_rd %0d got %h want 0", addr, rd_data); end
        @(posedge clk); #1;
        mem_r_en = 1'b0;
      end else if (c == 0) begin
        @(posedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    mem_w_en = 1'b1; alu_result = 32'd1036; st_val = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %b want 1", ready); end
    @(posedge clk); #1;
    rst = 1'b0; mem_w_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.state !== IDLE) begin n_bad++; $display("FAIL rst_mid_state got %0d want IDLE", dut.state); end
    n_cmp++;
    if ({sram_we_n, sram_dq_oe, rd_data, sram_addr} !== {1'b1, 1'b0, 32'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL rst_mid_regs got we_n=%b oe=%b rd=%h addr=%h", sram_we_n, sram_dq_oe, rd_data, sram_addr);
    end
  endtask

  // WAIT_CYCLES=1 instance: read then write with no extra idle bubble.
  task automatic test_back_to_back();
    logic [5:0] exp_rdy = 6'b100100;
    logic [5:0] exp_oe  = 6'b010000;
    @(posedge clk); #1;
    mem_r_en1 = 1'b1; alu_result1 = 32'd1024;
    for (int unsigned c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ready1, sram_dq_oe1, sram_we_n1} !== {exp_rdy[c], exp_oe[c], 1'b1}) begin
        n_bad++;
        $display("FAIL b2b_seq c%0d got rdy/oe/we_n=%b%b%b want %b%b1", c, ready1, sram_dq_oe1, sram_we_n1, exp_rdy[c], exp_oe[c]);
      end
      if (c == 4) begin
        n_cmp++;
        if (sram_addr1 !== 16'h1 || sram_dq_o1 !== 32'h0BAD_CAFE) begin
          n_bad++; $display("FAIL b2b_waddr got %h/%h want 0001/0badcafe", sram_addr1, sram_dq_o1);
        end
      end
      if (c == 2 || c == 5) begin
        n_cmp++;
        if (rd_data1 !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL b2b_rd c%0d got %h want cafef00d", c, rd_data1); end
      end
      if (c < 5) begin
        @(posedge clk); #1;
        if (c == 2) begin
          mem_r_en1 = 1'b0; mem_w_en1 = 1'b1; alu_result1 = 32'd1028; st_val1 = 32'h0BAD_CAFE;
        end
      end
    end
    @(posedge clk); #1;
    mem_w_en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write(1'b0, 32'd1028, 32'hDEAD_BEEF, 16'd1, 32'h0);
    test_read(32'd1028, 16'd1, 32'hDEAD_BEEF, 32'h0);
    test_write(1'b1, 32'd1032, 32'h1234_5678, 16'd2, 32'hDEAD_BEEF);
    test_addr_err(32'd1030);
    test_read(32'd1032, 16'd2, 32'h1234_5678, 32'h0);
    test_read(32'd263164, 16'hFFFF, 32'h0, 32'h1234_5678);
    test_addr_err(32'd1000);
    test_addr_err(32'd263168);
    test_read(32'd1028, 16'd1, 32'hDEAD_BEEF, 32'h0);
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
